// File: rtl/tdc_ctrl_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
// Optional macro TDC_SEQ_NUM_EN widens the frame with a leading sequence byte.
package tdc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      RUN,
      CAPTURE,
      SEND,
      DONE
   } state_e;

   localparam logic [3:0] STATUS_MARKER = 4'hA;

`ifdef TDC_SEQ_NUM_EN
   localparam int FRAME_BYTES = 5;
`else
   localparam int FRAME_BYTES = 4;
`endif

   localparam int IDX_W = $clog2(FRAME_BYTES);

   // Status byte: fixed marker nibble in the top half, timeout flag in bit 0.
   function automatic logic [7:0] statusByte(input logic timedOut);
      return {STATUS_MARKER, 3'b000, timedOut};
   endfunction

endpackage

// File: rtl/tdc_meas_ctrl_if.sv
// Byte stream handshake from the measurement sequencer to the UART transmitter.
// The sequencer is the master; the UART TX side is the slave.
interface tdc_meas_ctrl_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/tdc_stop_sync.sv
// Synchronizer and rising-edge detector for the asynchronous stop pin.
// The stop pulse appears SYNC_STAGES+1 cycles after the pin is first sampled high.
module tdc_stop_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stop_async,
   output logic stop_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   stopPrev_q;
   logic                   pulse_q;

   // Shift the raw pin through the synchronizer chain, then register a one-cycle
   // pulse on each low-to-high transition of the synchronized level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         stopPrev_q <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], stop_async};
         stopPrev_q <= sync_q[SYNC_STAGES-1];
         pulse_q    <= sync_q[SYNC_STAGES-1] & ~stopPrev_q;
      end
   end

   assign stop_pulse = pulse_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the TDC core: arms the TDC, counts coarse cycles until
// stop or timeout, captures coarse and fine values and streams a byte frame to UART TX.
// Optional macro TDC_SEQ_NUM_EN adds a leading 8-bit sequence number to every frame.
module tdc_meas_ctrl
   import tdc_ctrl_pkg::*;
#(
   parameter int COARSE_W       = 16,
   parameter int FINE_W         = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop_async,
   input  logic [FINE_W-1:0] fine_code,
   output logic              tdc_clr,
   output logic              tdc_en,
   output logic              busy,
   output logic              timeout,
   output logic              eot,
   tdc_meas_ctrl_if.master   tx
);

   localparam logic [COARSE_W-1:0] TIMEOUT_VAL = COARSE_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(FRAME_BYTES - 1);

   state_e              state_q, state_d;
   logic [COARSE_W-1:0] cnt_q, cnt_d;
   logic [15:0]         coarse_q, coarse_d;
   logic [7:0]          fine_q, fine_d;
   logic                timeout_q, timeout_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                stopPulse;
   logic [7:0]          frameByte;
`ifdef TDC_SEQ_NUM_EN
   logic [7:0]          seq_q, seq_d;
`endif

   tdc_stop_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_stop_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .stop_async (stop_async),
      .stop_pulse (stopPulse)
   );

   // State, counter, capture and frame-index registers; reset returns everything to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         coarse_q  <= '0;
         fine_q    <= '0;
         timeout_q <= 1'b0;
         idx_q     <= '0;
`ifdef TDC_SEQ_NUM_EN
         seq_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         coarse_q  <= coarse_d;
         fine_q    <= fine_d;
         timeout_q <= timeout_d;
         idx_q     <= idx_d;
`ifdef TDC_SEQ_NUM_EN
         seq_q     <= seq_d;
`endif
      end
   end

   // Next-state logic: a stop pulse in RUN beats the timeout compare in the same cycle,
   // and start is only honoured from IDLE so requests during a measurement are dropped.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      coarse_d  = coarse_q;
      fine_d    = fine_q;
      timeout_d = timeout_q;
      idx_d     = idx_q;
`ifdef TDC_SEQ_NUM_EN
      seq_d     = seq_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARM;
            end
         end
         ARM: begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + COARSE_W'(1);
            if (stopPulse) begin
               coarse_d                 = '0;
               coarse_d[COARSE_W-1:0]   = cnt_q;
               fine_d                   = '0;
               fine_d[FINE_W-1:0]       = fine_code;
               timeout_d                = 1'b0;
               state_d                  = CAPTURE;
            end else if (cnt_q == TIMEOUT_VAL) begin
               coarse_d                 = '0;
               coarse_d[COARSE_W-1:0]   = TIMEOUT_VAL;
               fine_d                   = '0;
               timeout_d                = 1'b1;
               state_d                  = CAPTURE;
            end
         end
         CAPTURE: begin
            idx_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            if (tx.tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
`ifdef TDC_SEQ_NUM_EN
            seq_d = seq_q + 8'd1;
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Frame byte selection from the captured values; the index only moves on a handshake,
   // so the selected byte stays stable while the transmitter stalls.
   always_comb begin
      frameByte = 8'h00;
`ifdef TDC_SEQ_NUM_EN
      case (idx_q)
         IDX_W'(0): frameByte = seq_q;
         IDX_W'(1): frameByte = coarse_q[15:8];
         IDX_W'(2): frameByte = coarse_q[7:0];
         IDX_W'(3): frameByte = fine_q;
         IDX_W'(4): frameByte = statusByte(timeout_q);
         default:   frameByte = 8'h00;
      endcase
`else
      case (idx_q)
         IDX_W'(0): frameByte = coarse_q[15:8];
         IDX_W'(1): frameByte = coarse_q[7:0];
         IDX_W'(2): frameByte = fine_q;
         IDX_W'(3): frameByte = statusByte(timeout_q);
         default:   frameByte = 8'h00;
      endcase
`endif
   end

   // Outputs decode directly from the current state so a reset silences them at once.
   always_comb begin
      tdc_clr     = (state_q == ARM);
      tdc_en      = (state_q == RUN);
      busy        = (state_q != IDLE);
      eot         = (state_q == DONE);
      timeout     = timeout_q;
      tx.tx_valid = (state_q == SEND);
      tx.tx_data  = (state_q == SEND) ? frameByte : 8'h00;
   end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl with a frame-level reference model.
// Build with TDC_SEQ_NUM_EN defined to exercise the sequence-number frame.
module tb_tdc_meas_ctrl;

   localparam int COARSE_W       = 16;
   localparam int FINE_W         = 8;
   localparam int TIMEOUT_CYCLES = 100;
   localparam int SYNC_STAGES    = 2;
   localparam int MAX_ITER       = 300;
`ifdef TDC_SEQ_NUM_EN
   localparam int NUM_BYTES = 5;
`else
   localparam int NUM_BYTES = 4;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop_async = 1'b0;
   logic [FINE_W-1:0] fine_code = '0;
   logic              tdc_clr;
   logic              tdc_en;
   logic              busy;
   logic              timeout;
   logic              eot;

   int checks   = 0;
   int errors   = 0;
   int seqModel = 0;

   tdc_meas_ctrl_if txIf ();

   tdc_meas_ctrl #(
      .COARSE_W       (COARSE_W),
      .FINE_W         (FINE_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop_async (stop_async),
      .fine_code  (fine_code),
      .tdc_clr    (tdc_clr),
      .tdc_en     (tdc_en),
      .busy       (busy),
      .timeout    (timeout),
      .eot        (eot),
      .tx         (txIf)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic st, input logic rdy);
      start         = s;
      stop_async    = st;
      txIf.tx_ready = rdy;
   endtask

   // One complete measurement. raiseCnt is the RUN counter value during which the stop
   // pin is raised (-1 = never); the stop pulse then lands SYNC_STAGES+1 counts later.
   task automatic runMeasurement(input string name, input int raiseCnt, input logic [7:0] fine,
                                 input bit slowReady, input bit noise, input int resetAfterHs);
      int         expCoarse;
      logic       expTo;
      logic [7:0] expFine;
      logic [7:0] expBytes[$];
      logic [7:0] gotBytes[$];
      int         clrCount, enCount, eotIter, lastHsIter, phase, idleBad;
      bit         stalled, done, startNext, resetNext, stopLvl, rdy, st;
      logic [7:0] stallData;
      logic [31:0] gotVal;

      clrCount = 0; enCount = 0; eotIter = -1; lastHsIter = -1; idleBad = 0;
      stalled = 0; done = 0; startNext = 0; resetNext = 0; stopLvl = 0;
      stallData = 8'h00;
      phase = $urandom_range(0, 2);

      if (raiseCnt >= 0 && raiseCnt + SYNC_STAGES + 1 <= TIMEOUT_CYCLES) begin
         expCoarse = raiseCnt + SYNC_STAGES + 1;
         expTo     = 1'b0;
         expFine   = fine;
      end else begin
         expCoarse = TIMEOUT_CYCLES;
         expTo     = 1'b1;
         expFine   = 8'h00;
      end
`ifdef TDC_SEQ_NUM_EN
      expBytes.push_back(8'(seqModel % 256));
`endif
      expBytes.push_back(8'(expCoarse / 256));
      expBytes.push_back(8'(expCoarse % 256));
      expBytes.push_back(expFine);
      expBytes.push_back(expTo ? 8'hA1 : 8'hA0);

      $display("[TB] measurement %s: raise=%0d fine=%0h slowReady=%0d noise=%0d", name, raiseCnt, fine, slowReady, noise);
      fine_code = fine;

      for (int t = 0; t < MAX_ITER && !done; t++) begin
         @(posedge clk);
         #1;
         if (resetNext) begin
            rst_n = 1'b0;
            #1;
            checkOutput({name, ":rst_valid"}, 32'(txIf.tx_valid), 32'd0);
            checkOutput({name, ":rst_data"}, 32'(txIf.tx_data), 32'd0);
            checkOutput({name, ":rst_busy"}, 32'(busy), 32'd0);
            checkOutput({name, ":rst_eot"}, 32'(eot), 32'd0);
            checkOutput({name, ":rst_en"}, 32'(tdc_en), 32'd0);
            checkOutput({name, ":rst_timeout"}, 32'(timeout), 32'd0);
            for (int i = 0; i < gotBytes.size(); i++) begin
               checkOutput($sformatf("%s:pre_rst_byte%0d", name, i), 32'(gotBytes[i]), 32'(expBytes[i]));
            end
            seqModel = 0;
            applyStimulus(1'b0, 1'b0, 1'b1);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (eot || busy || txIf.tx_valid) idleBad++;
            end
            checkOutput({name, ":post_rst_quiet"}, 32'(idleBad), 32'd0);
            return;
         end
         if (raiseCnt >= 0 && t == raiseCnt + 2) stopLvl = 1'b1;
         if (raiseCnt >= 0 && t == raiseCnt + 8) stopLvl = 1'b0;
         st        = (t == 0) || startNext || (noise && t == 3);
         startNext = 1'b0;
         rdy       = slowReady ? (((t + phase) % 3) == 0) : 1'b1;
         applyStimulus(st, stopLvl, rdy);

         @(negedge clk);
         if (t == 2) begin
            checkOutput({name, ":first_run_en"}, 32'(tdc_en), 32'd1);
            checkOutput({name, ":first_run_timeout"}, 32'(timeout), 32'd0);
         end
         clrCount += int'(tdc_clr);
         enCount  += int'(tdc_en);
         if (stalled) begin
            checkOutput({name, ":stall_valid"}, 32'(txIf.tx_valid), 32'd1);
            checkOutput({name, ":stall_data"}, 32'(txIf.tx_data), 32'(stallData));
         end
         stalled   = txIf.tx_valid && !txIf.tx_ready;
         stallData = txIf.tx_data;
         if (txIf.tx_valid && txIf.tx_ready) begin
            gotBytes.push_back(txIf.tx_data);
            lastHsIter = t;
            if (noise && (gotBytes.size() == 1 || gotBytes.size() == NUM_BYTES)) startNext = 1'b1;
            if (resetAfterHs >= 0 && gotBytes.size() == resetAfterHs) resetNext = 1'b1;
         end
         if (eot) begin
            done    = 1'b1;
            eotIter = t;
            checkOutput({name, ":done_busy"}, 32'(busy), 32'd1);
            checkOutput({name, ":done_valid"}, 32'(txIf.tx_valid), 32'd0);
         end
      end

      checkOutput({name, ":eot_seen"}, 32'(done), 32'd1);
      checkOutput({name, ":byte_count"}, 32'(gotBytes.size()), 32'(expBytes.size()));
      for (int i = 0; i < expBytes.size(); i++) begin
         gotVal = (i < gotBytes.size()) ? 32'(gotBytes[i]) : 32'hFFFF_FFFF;
         checkOutput($sformatf("%s:byte%0d", name, i), gotVal, 32'(expBytes[i]));
      end
      checkOutput({name, ":eot_latency"}, 32'(eotIter), 32'(lastHsIter + 1));
      checkOutput({name, ":clr_pulses"}, 32'(clrCount), 32'd1);
      checkOutput({name, ":run_cycles"}, 32'(enCount), 32'(expCoarse + 1));
      checkOutput({name, ":timeout_flag"}, 32'(timeout), 32'(expTo));

      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(1'b0, 1'b0, 1'b1);
         @(negedge clk);
         if (busy || eot || tdc_clr || tdc_en || txIf.tx_valid || (timeout !== expTo)) idleBad++;
      end
      checkOutput({name, ":idle_after"}, 32'(idleBad), 32'd0);
      if (done) seqModel = (seqModel + 1) % 256;
   endtask

   initial begin
      int activity;
      applyStimulus(1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_clr", 32'(tdc_clr), 32'd0);
      checkOutput("reset_en", 32'(tdc_en), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_timeout", 32'(timeout), 32'd0);
      checkOutput("reset_eot", 32'(eot), 32'd0);
      checkOutput("reset_valid", 32'(txIf.tx_valid), 32'd0);
      checkOutput("reset_data", 32'(txIf.tx_data), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      activity = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(1'b0, (i < 6), 1'b1);
         @(negedge clk);
         if (busy || tdc_en || tdc_clr || eot) activity++;
      end
      checkOutput("idle_stop_ignored", 32'(activity), 32'd0);

      runMeasurement("normal", 7, 8'h3C, 1'b0, 1'b0, -1);
      runMeasurement("timeout", -1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, -1);
      runMeasurement("backpressure", $urandom_range(0, 60), 8'($urandom_range(0, 255)), 1'b1, 1'b0, -1);
      runMeasurement("ignored_starts", $urandom_range(0, 60), 8'($urandom_range(0, 255)), 1'b0, 1'b1, -1);
      runMeasurement("collision", TIMEOUT_CYCLES - SYNC_STAGES - 1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, -1);
      runMeasurement("reset_send", $urandom_range(0, 60), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
      runMeasurement("after_reset", $urandom_range(0, 60), 8'($urandom_range(0, 255)), 1'b0, 1'b0, -1);
      for (int i = 0; i < 4; i++) begin
         runMeasurement($sformatf("random%0d", i), $urandom_range(0, 110), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
